ac_arbiter: RTL and testbench

AC_ARBITER -- requirements
Module: ac_arbiter

---
 rtl/ac_arbiter.sv | 141 ++++++++++++++
 tb/tb_ac_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_arbiter.sv
// Three-requester front end to an accumulator; fixed priority by default, round-robin when AC_ARB_RR_EN is defined.
// Latency req-to-ack: LOAD 4, READ 3, CLEAR 3, NOP 2 cycles; strobes and ack decode directly from state.
// Backpressure: one operation at a time; further requests wait on their level req until the arbiter is back in IDLE.
module ac_arbiter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [1:0]       op2,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic [2:0]       gnt,
    output logic [2:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] ac_in,
    output logic             ac_re,
    output logic             ac_we,
    output logic             ac_clear
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] XFER = 3'd2;
    localparam logic [2:0] CLR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    logic [2:0]       state;
    logic [1:0]       id_q;
    logic [WIDTH-1:0] din_q;

    logic             sel_vld;
    logic [1:0]       sel_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_din;

`ifdef AC_ARB_RR_EN
    logic [1:0] ptr;

    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Walk from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[add_mod3(ptr, 2'(k))]) begin
                sel_vld = 1'b1;
                sel_id  = add_mod3(ptr, 2'(k));
            end
        end
    end
`else
    always_comb begin
        sel_vld = |req;
        sel_id  = 2'd0;
        if (req[0])      sel_id = 2'd0;
        else if (req[1]) sel_id = 2'd1;
        else if (req[2]) sel_id = 2'd2;
    end
`endif

    always_comb begin
        sel_op  = op0;
        sel_din = din0;
        case (sel_id)
            2'd1: begin
                sel_op  = op1;
                sel_din = din1;
            end
            2'd2: begin
                sel_op  = op2;
                sel_din = din2;
            end
            default: begin
                sel_op  = op0;
                sel_din = din0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            id_q  <= 2'd0;
            din_q <= '0;
`ifdef AC_ARB_RR_EN
            ptr   <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        id_q  <= sel_id;
                        din_q <= sel_din;
                        case (sel_op)
                            OP_LOAD:  state <= LOAD;
                            OP_READ:  state <= XFER;
                            OP_CLEAR: state <= CLR;
                            default:  state <= DONE;
                        endcase
                    end
                end
                LOAD: state <= XFER;
                XFER: state <= DONE;
                CLR:  state <= DONE;
                DONE: begin
                    state <= IDLE;
`ifdef AC_ARB_RR_EN
                    ptr   <= add_mod3(id_q, 2'd1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs: the single-state encoding keeps the three strobes mutually exclusive.
    always_comb begin
        busy     = (state != IDLE);
        gnt      = busy ? (3'b001 << id_q) : 3'b000;
        ack      = (state == DONE) ? (3'b001 << id_q) : 3'b000;
        ac_re    = (state == LOAD);
        ac_we    = (state == XFER);
        ac_clear = (state == CLR);
        ac_in    = din_q;
    end

endmodule

// File: tb/tb_ac_arbiter.sv
// Bench for ac_arbiter: directed timing cases plus a scoreboard of expected completions checked on every ack.
module tb_ac_arbiter;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [1:0]       op0, op1, op2;
    logic [WIDTH-1:0] din0, din1, din2;
    logic [2:0]       gnt, ack;
    logic             busy;
    logic [WIDTH-1:0] ac_in;
    logic             ac_re, ac_we, ac_clear;

    ac_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op0(op0), .op1(op1), .op2(op2),
        .din0(din0), .din1(din1), .din2(din2),
        .gnt(gnt), .ack(ack), .busy(busy), .ac_in(ac_in),
        .ac_re(ac_re), .ac_we(ac_we), .ac_clear(ac_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       id;
        logic [WIDTH-1:0] din;
        logic [1:0]       op;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Completion monitor: strobes are tallied per operation and reconciled against the scoreboard at ack.
    int               re_n, we_n, clr_n;
    logic [WIDTH-1:0] re_din;
    logic [2:0]       prev_ack = 3'b000;
    bit               excl_bad = 1'b0;
    bit               gap_bad  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            re_n = 0; we_n = 0; clr_n = 0; re_din = '0;
            prev_ack = 3'b000;
        end else begin
            if ((int'(ac_re) + int'(ac_we) + int'(ac_clear)) > 1) excl_bad = 1'b1;
            if (prev_ack != 3'b000 && busy) gap_bad = 1'b1;
            if (ac_re) begin
                re_n++;
                re_din = ac_in;
            end
            if (ac_we)    we_n++;
            if (ac_clear) clr_n++;
            if (ack != 3'b000) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_ack", 32'(ack), 32'(3'b001 << e.id));
                    check("sb_re_count", re_n, (e.op == 2'b00) ? 1 : 0);
                    check("sb_we_count", we_n, (e.op == 2'b00 || e.op == 2'b01) ? 1 : 0);
                    check("sb_clr_count", clr_n, (e.op == 2'b10) ? 1 : 0);
                    if (e.op == 2'b00) check("sb_load_data", 32'(re_din), 32'(e.din));
                end
                re_n = 0; we_n = 0; clr_n = 0;
            end
            prev_ack = ack;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
        case (id)
            1:       begin op1 = op; din1 = d; end
            2:       begin op2 = op; din2 = d; end
            default: begin op0 = op; din0 = d; end
        endcase
        req = 3'(1 << id);
    endtask

    // Issue one request held until ack; checks latency and busy duration in cycles after the grant edge.
    task automatic run_op(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
        int lat, cyc, bcnt;
        bit got;
        set_req(id, op, d);
        sb.push_back('{id[1:0], d, op});
        lat  = (op == 2'b00) ? 4 : (op == 2'b11) ? 2 : 3;
        cyc  = 0;
        bcnt = 0;
        got  = 1'b0;
        while (!got && cyc < 12) begin
            step();
            cyc++;
            if (busy) bcnt++;
            if (ack != 3'b000) got = 1'b1;
        end
        check("op_timeout", 32'(got), 32'd1);
        check("op_latency", cyc, lat - 1);
        check("op_busy_cycles", bcnt, lat - 1);
        req = 3'b000;
        step();
        check("op_idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] order[4];
        logic [2:0] exp_order[4];
        logic [2:0] pg;
        int n_gnt, n_ack, cyc;

        rst = 1'b1; req = 3'b000;
        op0 = 2'b11; op1 = 2'b11; op2 = 2'b11;
        din0 = '0; din1 = '0; din2 = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({ac_re, ac_we, ac_clear}), 32'd0);
        check("rst_ac_in", 32'(ac_in), 32'd0);

        // LOAD on requester 0: grant+re, then we, then ack.
        set_req(0, 2'b00, 10'h2A5);
        sb.push_back('{2'd0, 10'h2A5, 2'b00});
        step();
        check("load_gnt", 32'(gnt), 32'b001);
        check("load_re", 32'({ac_re, ac_we, ac_clear}), 32'b100);
        check("load_ac_in", 32'(ac_in), 32'h2A5);
        step();
        check("load_we", 32'({ac_re, ac_we, ac_clear}), 32'b010);
        step();
        check("load_ack", 32'(ack), 32'b001);
        req = 3'b000;
        step();
        check("load_gnt_clear", 32'(gnt), 32'd0);
        check("load_ac_in_hold", 32'(ac_in), 32'h2A5);

        run_op(2, 2'b10, 10'h000);
        run_op(0, 2'b11, 10'h0F0);
        run_op(1, 2'b01, 10'h111);

        // Inputs change and req drops during LOAD; the running operation must complete unchanged.
        set_req(1, 2'b00, 10'h3FF);
        sb.push_back('{2'd1, 10'h3FF, 2'b00});
        step();
        din1 = 10'h000;
        req  = 3'b000;
        step();
        check("chg_ac_in", 32'(ac_in), 32'h3FF);
        step();
        check("chg_ack", 32'(ack), 32'b010);
        step();
        check("chg_idle", 32'(busy), 32'd0);

        // Reset during XFER of a LOAD aborts without ack.
        set_req(0, 2'b00, 10'h155);
        step();
        step();
        check("abort_in_xfer", 32'(ac_we), 32'd1);
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
        check("abort_outputs", 32'({gnt, ack, busy, ac_re, ac_we, ac_clear}), 32'd0);
        check("abort_ac_in", 32'(ac_in), 32'd0);
        pg = 3'b000;
        repeat (4) begin
            step();
            pg = pg | ack;
        end
        check("abort_no_ack", 32'(pg), 32'd0);

        // All three requesters held with READ.
`ifdef AC_ARB_RR_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        for (int i = 0; i < 4; i++) begin
            logic [1:0] eid;
            eid = (exp_order[i] == 3'b100) ? 2'd2 : (exp_order[i] == 3'b010) ? 2'd1 : 2'd0;
            sb.push_back('{eid, 10'h000, 2'b01});
            order[i] = 3'b000;
        end
        op0 = 2'b01; op1 = 2'b01; op2 = 2'b01;
        din0 = 10'h011; din1 = 10'h022; din2 = 10'h033;
        req = 3'b111;
        pg = 3'b000; n_gnt = 0; n_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            step();
            cyc++;
            if (gnt != 3'b000 && pg == 3'b000 && n_gnt < 4) begin
                order[n_gnt] = gnt;
                n_gnt++;
            end
            pg = gnt;
            if (ack != 3'b000) begin
                n_ack++;
                if (n_ack == 4) req = 3'b000;
            end
        end
        check("arb_ack_count", n_ack, 4);
        for (int i = 0; i < 4; i++) check($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
        step();
        step();
        check("arb_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
        end

        repeat (2) step();
        check("sb_drained", sb.size(), 0);
        check("strobe_exclusive", 32'(excl_bad), 32'd0);
        check("idle_gap", 32'(gap_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
